core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 85 ++++++++
 tb/tb_core_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/execute/memory-wait sequencer with program counter, ALU flags and retire counter
module core_sequencer #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  halt_pc,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  input  logic          is_mem,
  input  logic          mem_ready,
  input  logic          sc_o,
  input  logic          sc_clr,
  input  logic          sc_en,
  input  logic          pari,
  input  logic          pari_clr,
  input  logic          pari_en,
  output logic [D-1:0]  prog_ctr,
  output logic          instr_valid,
  output logic          mem_req,
  output logic          commit,
  output logic          sc_q,
  output logic          pari_q,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    DONE
  } state_t;

  state_t state;

  // Retire happens in the same cycle the decoder/memory say so, hence decoded
  // from state qualified by the live decoder and memory handshake.
  assign commit      = ((state == EXEC) && !is_mem) || ((state == MEM_WAIT) && mem_ready);
  assign mem_req     = (state == MEM_WAIT) || ((state == EXEC) && is_mem);
  assign instr_valid = (state == EXEC) || (state == MEM_WAIT);
  assign busy        = (state == FETCH) || (state == EXEC) || (state == MEM_WAIT);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prog_ctr    <= '0;
      instr_count <= '0;
      sc_q        <= 1'b0;
      pari_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            prog_ctr    <= '0;
            instr_count <= '0;
            sc_q        <= 1'b0;
            pari_q      <= 1'b0;
          end
        end
        FETCH:    state <= (prog_ctr == halt_pc) ? DONE : EXEC;
        EXEC:     state <= is_mem ? MEM_WAIT : FETCH;
        MEM_WAIT: if (mem_ready) state <= FETCH;
        default:  state <= IDLE;
      endcase

      // Architectural state moves only on retire; commit is never high in IDLE/DONE.
      if (commit) begin
        prog_ctr <= branch_en ? target : prog_ctr + D'(1);
        if (instr_count != {CW{1'b1}}) instr_count <= instr_count + CW'(1);
        if (sc_clr)       sc_q   <= 1'b0;
        else if (sc_en)   sc_q   <= sc_o;
        if (pari_clr)     pari_q <= 1'b0;
        else if (pari_en) pari_q <= pari;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - table-driven, directed and randomized program runs against a retire-level model
module tb_core_sequencer;
  localparam int D = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [D-1:0] halt_pc = '0;
  logic branch_en = 1'b0, is_mem = 1'b0, mem_ready = 1'b0;
  logic [D-1:0] target = '0;
  logic sc_o = 1'b0, sc_clr = 1'b0, sc_en = 1'b0, pari = 1'b0, pari_clr = 1'b0, pari_en = 1'b0;

  logic [D-1:0] prog_ctr, pc4;
  logic instr_valid, mem_req, commit, sc_q, pari_q, busy, done;
  logic iv4, mr4, cm4, sc4, pa4, bz4, dn4;
  logic [15:0] instr_count;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  core_sequencer #(.D(D), .CW(16)) dut (
    .clk(clk), .reset(rst_n), .start(start), .halt_pc(halt_pc),
    .branch_en(branch_en), .target(target), .is_mem(is_mem), .mem_ready(mem_ready),
    .sc_o(sc_o), .sc_clr(sc_clr), .sc_en(sc_en), .pari(pari), .pari_clr(pari_clr), .pari_en(pari_en),
    .prog_ctr(prog_ctr), .instr_valid(instr_valid), .mem_req(mem_req), .commit(commit),
    .sc_q(sc_q), .pari_q(pari_q), .busy(busy), .done(done), .instr_count(instr_count)
  );

  core_sequencer #(.D(D), .CW(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(start), .halt_pc(halt_pc),
    .branch_en(branch_en), .target(target), .is_mem(is_mem), .mem_ready(mem_ready),
    .sc_o(sc_o), .sc_clr(sc_clr), .sc_en(sc_en), .pari(pari), .pari_clr(pari_clr), .pari_en(pari_en),
    .prog_ctr(pc4), .instr_valid(iv4), .mem_req(mr4), .commit(cm4),
    .sc_q(sc4), .pari_q(pa4), .busy(bz4), .done(dn4), .instr_count(cnt4)
  );

  typedef struct {
    bit br; int tgt; bit mem; int w;
    bit scc; bit sce; bit sco; bit pcl; bit pe; bit p;
  } rom_t;

  typedef struct {
    int halt; int br_pc; int tgt; int mem_pc; int wt; bit flags; int mid;
    int exp_count; int exp_count4; int exp_cycles; int exp_memreq;
    bit exp_sc; bit exp_pari; int exp_pc2;
  } vec_t;

  rom_t rom[1024];
  int checks = 0;
  int failures = 0;
  int junk_mode = 0;
  bit wrap_mode = 1'b0;
  bit mon_en = 1'b0;
  int trace[$];
  int exp_trace[$];
  int memreq_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = '{default: 0};
  endtask

  // Instruction ROM + data memory stand-in: decoder fields follow prog_ctr,
  // mem_ready rises after the programmed number of wait cycles, and all
  // non-retiring cycles carry junk on the flag and mem_ready inputs.
  initial begin
    int k;
    bit pv;
    bit cc;
    rom_t e;
    k = 0;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k = (instr_valid && pv) ? k + 1 : 0;
      pv = instr_valid;
      if (wrap_mode && prog_ctr == 10'd1023) rom[0].br = 1'b0;
      e = rom[prog_ctr];
      branch_en = e.br;
      target = e.tgt[D-1:0];
      is_mem = e.mem;
      cc = instr_valid && (e.mem ? (k == e.w + 1) : (k == 0));
      if (instr_valid && e.mem && k >= 1) mem_ready = (k == e.w + 1);
      else mem_ready = (junk_mode == 1) ? 1'b1 : 1'($urandom);
      if (cc) begin
        sc_clr = e.scc; sc_en = e.sce; sc_o = e.sco;
        pari_clr = e.pcl; pari_en = e.pe; pari = e.p;
      end else if (junk_mode == 1) begin
        sc_clr = 1'b0; sc_en = 1'b1; sc_o = 1'b1;
        pari_clr = 1'b0; pari_en = 1'b1; pari = 1'b1;
      end else begin
        {sc_clr, sc_en, sc_o, pari_clr, pari_en, pari} = 6'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (commit) trace.push_back(int'(prog_ctr));
      if (mem_req) memreq_cnt++;
    end
  end

  // Retire-level reference: walks the program by PC, adding the cycle cost of
  // each instruction and applying the flag rules of every retired instruction.
  task automatic model(input int halt, output int n, output int cyc, output bit sc, output bit pa);
    int pc;
    pc = 0; n = 0; cyc = 1; sc = 1'b0; pa = 1'b0;
    exp_trace.delete();
    while (pc != halt && n < 5000) begin
      exp_trace.push_back(pc);
      cyc += rom[pc].mem ? 3 + rom[pc].w : 2;
      if (rom[pc].scc) sc = 1'b0;
      else if (rom[pc].sce) sc = rom[pc].sco;
      if (rom[pc].pcl) pa = 1'b0;
      else if (rom[pc].pe) pa = rom[pc].p;
      n++;
      pc = rom[pc].br ? rom[pc].tgt : (pc + 1) % 1024;
    end
  endtask

  // Pulses start, then counts clock edges after the start edge until done.
  task automatic run(input int mid, output int cyc);
    trace.delete();
    memreq_cnt = 0;
    @(posedge clk); #2;
    start = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 3000) begin
        chk("run_timeout_done", done, 1);
        break;
      end
      @(posedge clk); #2;
      cyc++;
      start = (cyc == mid);
    end
    start = 1'b0;
    mon_en = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    int cyc;
    int n;
    bit esc;
    bit epa;
    int h;
    vt[0] = '{3, -1, 0, -1, 0, 0, 0, 3, 3, 7, 0, 0, 0, 2};
    vt[1] = '{8, 1, 7, -1, 0, 0, 0, 3, 3, 7, 0, 0, 0, 7};
    vt[2] = '{1, -1, 0, 0, 3, 0, 0, 1, 1, 7, 5, 0, 0, -1};
    vt[3] = '{0, -1, 0, -1, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1};
    vt[4] = '{3, -1, 0, -1, 0, 1, 0, 3, 3, 7, 0, 0, 1, 2};
    vt[5] = '{4, -1, 0, 2, 2, 1, 0, 4, 4, 12, 4, 0, 1, 2};
    vt[6] = '{3, -1, 0, -1, 0, 0, 3, 3, 3, 7, 0, 0, 0, 2};
    vt[7] = '{20, -1, 0, -1, 0, 0, 0, 20, 15, 41, 0, 0, 0, 2};

    clear_rom();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_prog_ctr", prog_ctr, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_flags", {sc_q, pari_q}, 0);
    chk("rst_ctrl", {commit, mem_req, instr_valid, busy, done}, 0);
    chk("rst_dut4", {pc4, cnt4, cm4, mr4, iv4, bz4, dn4, sc4, pa4}, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      clear_rom();
      halt_pc = D'(vt[v].halt);
      if (vt[v].br_pc >= 0) begin
        rom[vt[v].br_pc].br = 1'b1;
        rom[vt[v].br_pc].tgt = vt[v].tgt;
      end
      if (vt[v].mem_pc >= 0) begin
        rom[vt[v].mem_pc].mem = 1'b1;
        rom[vt[v].mem_pc].w = vt[v].wt;
      end
      if (vt[v].flags) begin
        rom[0].sce = 1'b1; rom[0].sco = 1'b1; rom[0].pe = 1'b1; rom[0].p = 1'b1;
        rom[1].scc = 1'b1; rom[1].sce = 1'b1; rom[1].sco = 1'b1;
      end
      junk_mode = 1;
      run(vt[v].mid, cyc);
      chk($sformatf("v%0d_count", v), instr_count, vt[v].exp_count);
      chk($sformatf("v%0d_count_cw4", v), cnt4, vt[v].exp_count4);
      chk($sformatf("v%0d_cycles", v), cyc, vt[v].exp_cycles);
      chk($sformatf("v%0d_memreq", v), memreq_cnt, vt[v].exp_memreq);
      chk($sformatf("v%0d_sc_q", v), sc_q, vt[v].exp_sc);
      chk($sformatf("v%0d_pari_q", v), pari_q, vt[v].exp_pari);
      chk($sformatf("v%0d_pc_hold", v), prog_ctr, vt[v].halt);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_retired", v), trace.size(), vt[v].exp_count);
      if (vt[v].exp_pc2 >= 0)
        chk($sformatf("v%0d_pc2", v), (trace.size() > 2) ? trace[2] : -1, vt[v].exp_pc2);
    end

    // Restart from DONE after the 20-instruction run
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("restart_count", instr_count, 0);
    chk("restart_pc", prog_ctr, 0);
    chk("restart_done_busy", {done, busy}, 1);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("restart_finish", done, 1);

    // PC wrap 1023 -> 0
    clear_rom();
    rom[0].br = 1'b1;
    rom[0].tgt = 1023;
    halt_pc = 10'd1;
    wrap_mode = 1'b1;
    junk_mode = 0;
    run(0, cyc);
    wrap_mode = 1'b0;
    chk("wrap_retired", trace.size(), 3);
    chk("wrap_pc1", (trace.size() > 1) ? trace[1] : -1, 1023);
    chk("wrap_pc2", (trace.size() > 2) ? trace[2] : -1, 0);
    chk("wrap_count", instr_count, 3);

    // Reset in MEM_WAIT abandons the memory instruction
    clear_rom();
    rom[0].mem = 1'b1;
    rom[0].w = 10;
    halt_pc = 10'd5;
    trace.delete();
    @(posedge clk); #2;
    start = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("mw_before_reset", {mem_req, instr_valid, busy}, 7);
    rst_n = 1'b0;
    #1;
    chk("mw_reset_ctrl", {commit, mem_req, instr_valid, busy, done}, 0);
    chk("mw_reset_state", {prog_ctr, instr_count, sc_q, pari_q}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("mw_idle_after", {busy, done, commit}, 0);
    chk("mw_no_commit", trace.size(), 0);

    // Randomized programs: forward-only branches so every run reaches halt_pc
    for (int r = 0; r < 8; r++) begin
      clear_rom();
      h = 18 + int'($urandom % 12);
      halt_pc = D'(h);
      for (int pc = 0; pc < 32; pc++) begin
        rom[pc].mem = ($urandom % 3) == 0;
        rom[pc].w = int'($urandom % 4);
        rom[pc].br = (pc < h) && (($urandom % 6) == 0);
        if (rom[pc].br) rom[pc].tgt = pc + 1 + int'($urandom % (h - pc));
        rom[pc].scc = ($urandom % 4) == 0;
        rom[pc].sce = 1'($urandom);
        rom[pc].sco = 1'($urandom);
        rom[pc].pcl = ($urandom % 4) == 0;
        rom[pc].pe = 1'($urandom);
        rom[pc].p = 1'($urandom);
      end
      model(h, n, cyc, esc, epa);
      junk_mode = 0;
      run((r % 2 == 1) ? 5 : 0, cyc);
      chk($sformatf("r%0d_count", r), instr_count, n);
      chk($sformatf("r%0d_count_cw4", r), cnt4, (n > 15) ? 15 : n);
      chk($sformatf("r%0d_sc_q", r), sc_q, esc);
      chk($sformatf("r%0d_pari_q", r), pari_q, epa);
      chk($sformatf("r%0d_pc_hold", r), prog_ctr, h);
      chk($sformatf("r%0d_retired", r), trace.size(), exp_trace.size());
      for (int i = 0; i < exp_trace.size(); i++)
        chk($sformatf("r%0d_trace%0d", r, i), (i < trace.size()) ? trace[i] : -1, exp_trace[i]);
      begin
        int ecyc;
        model(h, n, ecyc, esc, epa);
        chk($sformatf("r%0d_cycles", r), cyc, ecyc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
